// File: rtl/bayer_line_window_ctrl_pkg.sv
// Shared constants and type codes for the Bayer line-window controller and its line RAMs.
// Pixel width, row counter width, FSM state codes and the Bayer phase encoding.
package bayer_line_window_ctrl_pkg;

    localparam int PIX_W    = 8;
    localparam int ROW_BITS = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Phase of a pixel within the 2x2 Bayer tile, {row_odd, col_odd}.
    typedef enum logic [1:0] {
        PH_R  = 2'd0,
        PH_GR = 2'd1,
        PH_GB = 2'd2,
        PH_B  = 2'd3
    } bayer_phase_e;

    function automatic bayer_phase_e bayer_phase(input logic row_odd, input logic col_odd);
        return bayer_phase_e'({row_odd, col_odd});
    endfunction

endpackage

// File: rtl/bayer_line_window_ctrl_line_ram_dp.sv
// Single-clock dual-port line RAM, read-first on port A, 1-cycle registered read.
// Port B is write-only; no reset on storage or read data, no backpressure.
module bayer_line_window_ctrl_line_ram_dp
    import bayer_line_window_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk_i,
    input  logic                 en_a_i,
    input  logic                 we_a_i,
    input  logic [ADDR_BITS-1:0] addr_a_i,
    input  logic [PIX_W-1:0]     wdata_a_i,
    output logic [PIX_W-1:0]     rdata_a_o,
    input  logic                 en_b_i,
    input  logic                 we_b_i,
    input  logic [ADDR_BITS-1:0] addr_b_i,
    input  logic [PIX_W-1:0]     wdata_b_i
);

    logic [PIX_W-1:0] mem_q [2**ADDR_BITS];
    logic [PIX_W-1:0] rdata_q;

    // Read and write of the same address in one cycle returns the old word.
    always_ff @(posedge clk_i) begin
        if (en_a_i) begin
            rdata_q <= mem_q[addr_a_i];
            if (we_a_i) begin
                mem_q[addr_a_i] <= wdata_a_i;
            end
        end
        if (en_b_i && we_b_i) begin
            mem_q[addr_b_i] <= wdata_b_i;
        end
    end

    assign rdata_a_o = rdata_q;

endmodule

// File: rtl/bayer_line_window_ctrl.sv
// Line-buffer controller: raster Bayer stream in, vertical 3-tap column (r-2, r-1, r) out.
// Latency 1 cycle s_valid -> m_valid; no backpressure, the input stream is free-running.
module bayer_line_window_ctrl
    import bayer_line_window_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int ADDR_BITS = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    input  logic             s_eol,
    output logic             m_valid,
    output logic [PIX_W-1:0] m_top,
    output logic [PIX_W-1:0] m_mid,
    output logic [PIX_W-1:0] m_bot,
    output logic             m_sol,
    output logic             m_eol,
    output logic             m_row_odd,
    output logic             m_col_odd,
    output logic             err_len
);

    localparam logic [ADDR_BITS-1:0] LAST_COL = ADDR_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0]  ROW_MAX  = '1;
    localparam logic [ROW_BITS-1:0]  ROW_ONE  = ROW_BITS'(1);

    state_e                state_q, state_d, cur_state;
    logic [ADDR_BITS-1:0]  col_q, col_d, cur_col;
    logic [ROW_BITS-1:0]   row_q, row_d, cur_row;
    logic                  sel_q, sel_d, cur_sel;
    logic                  ovf_q, ovf_d, cur_ovf;
    logic                  err_q, err_d;
    logic                  restart, active, store, line_end, emit;

    logic                  vld_q, vld_d;
    logic [PIX_W-1:0]      bot_q, bot_d;
    logic                  sol_q, sol_d, eol_q, eol_d;
    logic                  rodd_q, rodd_d, codd_q, codd_d;
    logic                  osel_q, osel_d;
    logic [PIX_W-1:0]      rd0, rd1;

    always_comb begin
        // A start-of-frame pixel is evaluated as if the counters were already cleared.
        restart   = s_valid & s_sof;
        cur_state = restart ? ST_FILL : state_q;
        cur_col   = restart ? '0 : col_q;
        cur_row   = restart ? '0 : row_q;
        cur_sel   = restart ? 1'b0 : sel_q;
        cur_ovf   = ~restart & ovf_q;

        active    = s_valid & (cur_state != ST_IDLE);
        store     = active & ~cur_ovf;
        line_end  = active & s_eol;
        emit      = store & (cur_state == ST_RUN);

        state_d   = cur_state;
        col_d     = cur_col;
        row_d     = cur_row;
        sel_d     = cur_sel;
        ovf_d     = cur_ovf;
        err_d     = ~restart & err_q;

        if (line_end) begin
            col_d = '0;
            ovf_d = 1'b0;
            sel_d = ~cur_sel;
            if (cur_row != ROW_MAX) begin
                row_d = cur_row + 1'b1;
            end
            if (cur_col != LAST_COL) begin
                err_d = 1'b1;
            end
            if (cur_state == ST_FILL && cur_row == ROW_ONE) begin
                state_d = ST_RUN;
            end
        end else if (store) begin
            if (cur_col == LAST_COL) begin
                ovf_d = 1'b1;
                err_d = 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
            end
        end

        vld_d  = emit;
        bot_d  = emit ? s_data : '0;
        sol_d  = emit & (cur_col == '0);
        eol_d  = emit & s_eol;
        codd_d = emit & cur_col[0];
        rodd_d = emit & ~cur_row[0];
        osel_d = cur_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            sel_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            bot_q   <= '0;
            sol_q   <= 1'b0;
            eol_q   <= 1'b0;
            codd_q  <= 1'b0;
            rodd_q  <= 1'b0;
            osel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sel_q   <= sel_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            bot_q   <= bot_d;
            sol_q   <= sol_d;
            eol_q   <= eol_d;
            codd_q  <= codd_d;
            rodd_q  <= rodd_d;
            osel_q  <= osel_d;
        end
    end

    // buf[sel] holds row r-1, buf[~sel] holds row r-2 and receives row r.
    bayer_line_window_ctrl_line_ram_dp #(.ADDR_BITS(ADDR_BITS)) u_buf0 (
        .clk_i     (clk),
        .en_a_i    (store),
        .we_a_i    (store & cur_sel),
        .addr_a_i  (cur_col),
        .wdata_a_i (s_data),
        .rdata_a_o (rd0),
        .en_b_i    (1'b0),
        .we_b_i    (1'b0),
        .addr_b_i  ('0),
        .wdata_b_i ('0)
    );

    bayer_line_window_ctrl_line_ram_dp #(.ADDR_BITS(ADDR_BITS)) u_buf1 (
        .clk_i     (clk),
        .en_a_i    (store),
        .we_a_i    (store & ~cur_sel),
        .addr_a_i  (cur_col),
        .wdata_a_i (s_data),
        .rdata_a_o (rd1),
        .en_b_i    (1'b0),
        .we_b_i    (1'b0),
        .addr_b_i  ('0),
        .wdata_b_i ('0)
    );

    // RAM read registers are not reset, so their data is masked while idle.
    assign m_valid   = vld_q;
    assign m_mid     = vld_q ? (osel_q ? rd1 : rd0) : '0;
    assign m_top     = vld_q ? (osel_q ? rd0 : rd1) : '0;
    assign m_bot     = bot_q;
    assign m_sol     = sol_q;
    assign m_eol     = eol_q;
    assign m_row_odd = rodd_q;
    assign m_col_odd = codd_q;
    assign err_len   = err_q;

endmodule

// File: tb/tb_bayer_line_window_ctrl.sv
// Directed bench for bayer_line_window_ctrl at IMG_WIDTH=4 with a line-history model.
module tb_bayer_line_window_ctrl;

    localparam int W = 4;

    logic       clk, rst;
    logic       s_valid, s_sof, s_eol;
    logic [7:0] s_data;
    logic       m_valid, m_sol, m_eol, m_row_odd, m_col_odd, err_len;
    logic [7:0] m_top, m_mid, m_bot;

    bayer_line_window_ctrl #(.IMG_WIDTH(W), .ADDR_BITS(11)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof),
        .s_eol(s_eol), .m_valid(m_valid), .m_top(m_top), .m_mid(m_mid), .m_bot(m_bot),
        .m_sol(m_sol), .m_eol(m_eol), .m_row_odd(m_row_odd), .m_col_odd(m_col_odd),
        .err_len(err_len)
    );

    int tests = 0;
    int fails = 0;
    bit cmp_en = 0;

    // Model: the two most recent completed lines plus the line being built.
    int p1[W], p2[W], cur[W];
    bit mdl_act, mdl_ovf, mdl_err;
    int mdl_row, mdl_col;
    bit e_vld, e_sol, e_eol, e_codd, e_rodd;
    int e_top, e_mid, e_bot;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        tests++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_exp();
        e_vld = 0; e_sol = 0; e_eol = 0; e_codd = 0; e_rodd = 0;
        e_top = 0; e_mid = 0; e_bot = 0;
    endtask

    task automatic model_close();
        p2 = p1;
        p1 = cur;
        cur = p2;
        if (mdl_row < 4095) mdl_row++;
        mdl_col = 0;
        mdl_ovf = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit sof, input bit eol);
        clear_exp();
        if (!v) return;
        if (sof) begin
            mdl_act = 1; mdl_row = 0; mdl_col = 0; mdl_ovf = 0; mdl_err = 0;
            cur = p2;
        end
        if (!mdl_act) return;
        if (mdl_ovf) begin
            if (eol) model_close();
            return;
        end
        cur[mdl_col] = d;
        if (mdl_row >= 2) begin
            e_vld  = 1;
            e_top  = p2[mdl_col];
            e_mid  = p1[mdl_col];
            e_bot  = d;
            e_sol  = (mdl_col == 0);
            e_eol  = eol;
            e_codd = mdl_col % 2;
            e_rodd = (mdl_row - 1) % 2;
        end
        if (eol) begin
            if (mdl_col != W - 1) mdl_err = 1;
            model_close();
        end else if (mdl_col == W - 1) begin
            mdl_err = 1;
            mdl_ovf = 1;
        end else begin
            mdl_col++;
        end
    endtask

    task automatic model_reset();
        mdl_act = 0; mdl_err = 0; mdl_ovf = 0; mdl_row = 0; mdl_col = 0;
        clear_exp();
    endtask

    task automatic drive(input bit v, input int d, input bit sof, input bit eol);
        @(negedge clk);
        s_valid = v; s_data = 8'(d); s_sof = sof; s_eol = eol;
        model_step(v, d, sof, eol);
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int base, input int n, input int gap,
                             input bit sof, input bit eol_last);
        for (int i = 0; i < n; i++) begin
            drive(1, base + i, sof && (i == 0), eol_last && (i == n - 1));
            for (int g = 0; g < gap; g++) drive(0, 0, 0, 0);
        end
    endtask

    // Cycle-by-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cmp_en) begin
                chk("valid", m_valid, e_vld);
                if (e_vld) begin
                    chk("top", m_top, e_top);
                    chk("mid", m_mid, e_mid);
                    chk("bot", m_bot, e_bot);
                    chk("sol", m_sol, e_sol);
                    chk("eol", m_eol, e_eol);
                    chk("col_odd", m_col_odd, e_codd);
                    chk("row_odd", m_row_odd, e_rodd);
                end
                chk("err_len", err_len, mdl_err);
            end
        end
    end

    initial begin
        for (int i = 0; i < W; i++) begin
            p1[i] = 0; p2[i] = 0; cur[i] = 0;
        end
        model_reset();
        rst = 1; s_valid = 0; s_data = 0; s_sof = 0; s_eol = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_bot", m_bot, 0);
        chk("rst_flags", {m_sol, m_eol, m_row_odd, m_col_odd}, 0);
        chk("rst_err", err_len, 0);
        @(negedge clk);
        rst = 0;
        cmp_en = 1;

        // Pixels before any start-of-frame are dropped.
        drive(1, 99, 0, 0);
        drive(1, 98, 0, 1);
        chk("idle_drop", m_valid, 0);

        // Frame 1: rows 0..3, contiguous.
        send_line(1, 4, 0, 1, 1);
        send_line(5, 4, 0, 0, 1);
        chk("fill_no_valid", m_valid, 0);
        drive(1, 9, 0, 0);
        chk("r2c0_valid", m_valid, 1);
        chk("r2c0_col", {m_top, m_mid, m_bot}, {8'd1, 8'd5, 8'd9});
        chk("r2c0_sol", m_sol, 1);
        chk("r2_row_odd", m_row_odd, 1);
        drive(1, 10, 0, 0);
        drive(1, 11, 0, 0);
        drive(1, 12, 0, 1);
        chk("r2c3_col", {m_top, m_mid, m_bot}, {8'd4, 8'd8, 8'd12});
        chk("r2c3_eol", {m_eol, m_col_odd}, 2'b11);
        drive(1, 13, 0, 0);
        chk("r3c0_col", {m_top, m_mid, m_bot}, {8'd5, 8'd9, 8'd13});
        chk("r3_row_odd", m_row_odd, 0);
        send_line(14, 3, 0, 0, 1);

        // Row 4 with two idle cycles after every pixel.
        drive(1, 17, 0, 0);
        chk("gap_col", {m_top, m_mid, m_bot}, {8'd9, 8'd13, 8'd17});
        drive(0, 0, 0, 0);
        chk("gap_idle", m_valid, 0);
        drive(0, 0, 0, 0);
        send_line(18, 3, 2, 0, 1);

        // Short line, then a full line reading back through it.
        send_line(21, 3, 0, 0, 1);
        chk("short_err", err_len, 1);
        drive(1, 25, 0, 0);
        chk("after_short", {m_top, m_mid, m_bot, 7'd0, m_sol}, {8'd17, 8'd21, 8'd25, 8'd1});
        send_line(26, 3, 0, 0, 1);

        // Frame 2: new start clears the error; overlong row 2.
        drive(1, 31, 1, 0);
        chk("sof_clr_err", err_len, 0);
        send_line(32, 3, 0, 0, 1);
        send_line(35, 4, 0, 0, 1);
        send_line(41, 4, 0, 0, 0);
        chk("long_c3", {m_valid, m_bot}, {1'b1, 8'd44});
        chk("long_err", err_len, 1);
        drive(1, 45, 0, 0);
        chk("long_drop5", m_valid, 0);
        drive(1, 46, 0, 0);
        drive(1, 47, 0, 1);
        chk("long_drop_eol", m_valid, 0);
        drive(1, 51, 0, 0);
        chk("after_long", {m_top, m_mid, m_bot}, {8'd35, 8'd41, 8'd51});
        send_line(52, 3, 0, 0, 1);
        send_line(61, 2, 0, 0, 0);
        chk("pre_rst_valid", m_valid, 1);

        // Asynchronous reset mid-line.
        @(negedge clk);
        rst = 1;
        s_valid = 0; s_sof = 0; s_eol = 0;
        model_reset();
        #1;
        chk("async_rst", {m_valid, m_top, m_mid, m_bot, m_sol, m_eol, err_len}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        drive(0, 0, 0, 0);

        // Frame 3 after reset must refill two lines.
        send_line(71, 4, 0, 1, 1);
        chk("refill_r0", m_valid, 0);
        send_line(75, 4, 0, 0, 1);
        chk("refill_r1", m_valid, 0);
        drive(1, 81, 0, 0);
        chk("refill_r2", {m_valid, m_top, m_mid, m_bot}, {1'b1, 8'd71, 8'd75, 8'd81});
        send_line(82, 3, 0, 0, 1);

        // Start and end of line on the same pixel.
        drive(1, 90, 1, 1);
        chk("sof_eol_err", {m_valid, err_len}, 2'b01);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
